// File: rtl/hsv_share_arb_pkg.sv
// Shared widths, requester indices and the HSV result record for the
// two-requester RGB->HSV share arbiter.
package hsv_share_arb_pkg;

    localparam int HSV_H_W       = 14;
    localparam int HSV_SV_W      = 8;
    localparam int RGB_W         = 24;
    localparam int TAG_W_DEFAULT = 11;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        MAX_R = 2'd0,
        MAX_G = 2'd1,
        MAX_B = 2'd2
    } max_sel_e;

    typedef struct packed {
        logic [HSV_H_W-1:0]  h;
        logic [HSV_SV_W-1:0] s;
        logic [HSV_SV_W-1:0] v;
    } hsv_t;

endpackage

// File: rtl/hsv_share_arb_if.sv
// Request/response bundle between the pixel requesters (master) and the
// shared HSV converter (slave).
interface hsv_share_arb_if
    import hsv_share_arb_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEFAULT
) ();

    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [RGB_W-1:0]    req_rgb0;
    logic [RGB_W-1:0]    req_rgb1;
    logic [TAG_W-1:0]    req_tag0;
    logic [TAG_W-1:0]    req_tag1;

    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [HSV_H_W-1:0]  rsp_h;
    logic [HSV_SV_W-1:0] rsp_s;
    logic [HSV_SV_W-1:0] rsp_v;
    logic [TAG_W-1:0]    rsp_tag;

    modport master (
        output req_valid, req_rgb0, req_rgb1, req_tag0, req_tag1, rsp_ready,
        input  req_ready, rsp_valid, rsp_h, rsp_s, rsp_v, rsp_tag
    );

    modport slave (
        input  req_valid, req_rgb0, req_rgb1, req_tag0, req_tag1, rsp_ready,
        output req_ready, rsp_valid, rsp_h, rsp_s, rsp_v, rsp_tag
    );

endinterface

// File: rtl/hsv_share_arb_hsv_core.sv
// Combinational RGB->HSV converter: V=max, S=max-min, H as a 14-bit signed
// offset within the winning channel's sector (R, then G, then B on ties).
module hsv_core
    import hsv_share_arb_pkg::*;
(
    input  logic [RGB_W-1:0] rgb,
    output hsv_t             hsv
);

    logic [7:0]         r, g, b;
    logic [7:0]         mx, mn, diff;
    logic [HSV_H_W-1:0] r_x, g_x, b_x, diff_x;
    max_sel_e           sel;

    assign r = rgb[23:16];
    assign g = rgb[15:8];
    assign b = rgb[7:0];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        sel = MAX_B;
        mx  = b;
        if (r >= g && r >= b) begin
            sel = MAX_R;
            mx  = r;
        end else if (g >= b) begin
            sel = MAX_G;
            mx  = g;
        end

        mn = r;
        if (g < mn) mn = g;
        if (b < mn) mn = b;
        diff = mx - mn;

        r_x    = {{(HSV_H_W-8){1'b0}}, r};
        g_x    = {{(HSV_H_W-8){1'b0}}, g};
        b_x    = {{(HSV_H_W-8){1'b0}}, b};
        diff_x = {{(HSV_H_W-8){1'b0}}, diff};

        hsv   = '0;
        hsv.s = diff;
        hsv.v = mx;
        // Arithmetic wraps modulo 2^14, which is exactly the two's-complement hue.
        if (mx != 8'd0) begin
            unique case (sel)
                MAX_R:   hsv.h = g_x - b_x;
                MAX_G:   hsv.h = (diff_x << 1) + b_x - r_x;
                default: hsv.h = (diff_x << 2) + r_x - g_x;
            endcase
        end
    end

endmodule

// File: rtl/hsv_share_arb.sv
// Round-robin share of one HSV core between two requesters, with an operand
// stage, a result stage, and saturating per-requester completion counters.
module hsv_share_arb
    import hsv_share_arb_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    hsv_share_arb_if.slave   bus,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic             s1_v_q, s1_v_d;
    logic [RGB_W-1:0] s1_rgb_q, s1_rgb_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s1_own_q, s1_own_d;

    logic             s2_v_q, s2_v_d;
    hsv_t             s2_hsv_q, s2_hsv_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic             s2_own_q, s2_own_d;

    logic             rr_last_q, rr_last_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic             s2_move, s1_move, s1_free;
    logic             accept, grant_idx;
    logic [1:0]       grant;
    hsv_t             core_hsv;

    hsv_core u_core (
        .rgb (s1_rgb_q),
        .hsv (core_hsv)
    );

    // Backpressure ripples rsp_ready -> s2 -> s1 -> req_ready in one cycle.
    always_comb begin
        s2_move   = s2_v_q & bus.rsp_ready[s2_own_q];
        s1_move   = s1_v_q & (~s2_v_q | s2_move);
        s1_free   = ~s1_v_q | s1_move;
        grant_idx = (&bus.req_valid) ? ~rr_last_q : bus.req_valid[REQ1];
        grant     = (|bus.req_valid) ? (2'b01 << grant_idx) : 2'b00;
        accept    = (|bus.req_valid) & s1_free;
    end

    always_comb begin
        rr_last_d = rr_last_q;
        s1_v_d    = s1_v_q;
        s1_rgb_d  = s1_rgb_q;
        s1_tag_d  = s1_tag_q;
        s1_own_d  = s1_own_q;
        if (accept) begin
            rr_last_d = grant_idx;
            s1_v_d    = 1'b1;
            s1_own_d  = grant_idx;
            s1_rgb_d  = (grant_idx == REQ1) ? bus.req_rgb1 : bus.req_rgb0;
            s1_tag_d  = (grant_idx == REQ1) ? bus.req_tag1 : bus.req_tag0;
        end else if (s1_move) begin
            s1_v_d = 1'b0;
        end
    end

    always_comb begin
        s2_v_d   = s2_v_q;
        s2_hsv_d = s2_hsv_q;
        s2_tag_d = s2_tag_q;
        s2_own_d = s2_own_q;
        if (s1_move) begin
            s2_v_d   = 1'b1;
            s2_hsv_d = core_hsv;
            s2_tag_d = s1_tag_q;
            s2_own_d = s1_own_q;
        end else if (s2_move) begin
            s2_v_d = 1'b0;
        end
    end

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (s2_move && s2_own_q == REQ0 && !(&cnt0_q)) cnt0_d = cnt0_q + CNT_W'(1);
        if (s2_move && s2_own_q == REQ1 && !(&cnt1_q)) cnt1_d = cnt1_q + CNT_W'(1);
    end

    // rr_last resets to 1 so requester 0 wins the first contested cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= 1'b1;
            s1_v_q    <= 1'b0;
            s1_rgb_q  <= '0;
            s1_tag_q  <= '0;
            s1_own_q  <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_hsv_q  <= '0;
            s2_tag_q  <= '0;
            s2_own_q  <= 1'b0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            rr_last_q <= rr_last_d;
            s1_v_q    <= s1_v_d;
            s1_rgb_q  <= s1_rgb_d;
            s1_tag_q  <= s1_tag_d;
            s1_own_q  <= s1_own_d;
            s2_v_q    <= s2_v_d;
            s2_hsv_q  <= s2_hsv_d;
            s2_tag_q  <= s2_tag_d;
            s2_own_q  <= s2_own_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

    assign bus.req_ready = grant & {2{s1_free}};
    assign bus.rsp_valid = s2_v_q ? (2'b01 << s2_own_q) : 2'b00;
    assign bus.rsp_h     = s2_hsv_q.h;
    assign bus.rsp_s     = s2_hsv_q.s;
    assign bus.rsp_v     = s2_hsv_q.v;
    assign bus.rsp_tag   = s2_tag_q;
    assign cnt0          = cnt0_q;
    assign cnt1          = cnt1_q;

endmodule
